// File: rtl/mem_pkg.sv
// Shared types and widths for the wait-state memory responder.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Single-outstanding request/response bus between an initiator and mem_responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              ready;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata, err
  );

endinterface

// File: rtl/ram_bank.sv
// Word-wide storage with per-byte write enables and a registered read port.
module ram_bank import mem_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] rdata_d;

  // Contents are deliberately never reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request FSM with programmable wait states in front of a byte-enabled RAM bank.
module mem_responder import mem_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              err_q, err_d;

  logic              aligned;
  logic              in_range;
  logic              access;
  logic              ram_en;
  logic [WORD_W-1:0] ram_rdata;
  logic              ready;
  logic              err;
  logic [WORD_W-1:0] rdata;

  assign aligned  = (bus.addr[1:0] == 2'b00);
  assign in_range = (bus.addr[WORD_W-1:AW+2] == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  // The error decision is taken at acceptance so the access cycle only gates the RAM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = BUSY;
          cnt_d   = WAIT_LD;
          we_d    = bus.we;
          idx_d   = bus.addr[AW+1:2];
          wdata_d = bus.wdata;
          be_d    = bus.be;
          err_d   = !(aligned && in_range);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    access = (state_q == BUSY) && (cnt_q == '0);
    ram_en = access && !err_q;
    ready  = (state_q == DONE);
    err    = ready && err_q;
    rdata  = (ready && !err_q && !we_q) ? ram_rdata : '0;
  end

  ram_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (ram_rdata)
  );

  assign bus.ready = ready;
  assign bus.err   = err;
  assign bus.rdata = rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut2 has WAIT=2/DEPTH=256, dut0 has WAIT=0/DEPTH=16.
module tb_mem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_responder_if bus2();
  mem_responder_if bus0();

  mem_responder #(.DEPTH(256), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mem_responder #(.DEPTH(16),  .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel=1 addresses dut0, sel=0 addresses dut2.
  task automatic drive(input bit sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    if (sel) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d; bus0.be = b;
    end else begin
      bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wdata = d; bus2.be = b;
    end
  endtask

  task automatic wait_ready(input bit sel, output int n, output logic [31:0] rd,
                            output logic e, output logic after);
    n = -1; rd = 'x; e = 1'bx; after = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if ((sel ? bus0.ready : bus2.ready) === 1'b1) begin
        n  = k;
        rd = sel ? bus0.rdata : bus2.rdata;
        e  = sel ? bus0.err : bus2.err;
        break;
      end
    end
    if (sel) bus0.req = 1'b0; else bus2.req = 1'b0;
    if (n > 0) begin
      @(posedge clk); #1;
      after = sel ? bus0.ready : bus2.ready;
    end
  endtask

  task automatic transact(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output int n, output logic [31:0] rd,
                          output logic e, output logic after);
    @(negedge clk);
    drive(sel, 1'b1, w, a, d, b);
    wait_ready(sel, n, rd, e, after);
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus2.ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready2: got %b expected 0", bus2.ready); end
    checks++; if (bus2.err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err2: got %b expected 0", bus2.err); end
    checks++; if (bus2.rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_rdata2: got %h expected 00000000", bus2.rdata); end
    checks++; if (bus0.ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready0: got %b expected 0", bus0.ready); end
    checks++; if (bus0.err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err0: got %b expected 0", bus0.err); end
    checks++; if (bus0.rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_rdata0: got %h expected 00000000", bus0.rdata); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_word();
    int n; logic [31:0] rd; logic e, af;
    transact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, n, rd, e, af);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL wr_latency: got %0d expected 4", n); end
    checks++; if (e !== 1'b0) begin failures++; $display("[TB] FAIL wr_err: got %b expected 0", e); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL wr_rdata: got %h expected 00000000", rd); end
    checks++; if (af !== 1'b0) begin failures++; $display("[TB] FAIL wr_ready_width: got %b expected 0", af); end
    transact(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL rd_latency: got %0d expected 4", n); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("[TB] FAIL rd_err: got %b expected 0", e); end
  endtask

  task automatic test_byte_lanes();
    int n; logic [31:0] rd; logic e, af;
    transact(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'h2, n, rd, e, af);
    checks++; if (e !== 1'b0) begin failures++; $display("[TB] FAIL be2_err: got %b expected 0", e); end
    transact(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("[TB] FAIL be2_merge: got %h expected deadaaef", rd); end
    transact(1'b0, 1'b1, 32'h10, 32'h11111111, 4'h0, n, rd, e, af);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL be0_latency: got %0d expected 4", n); end
    checks++; if (e !== 1'b0) begin failures++; $display("[TB] FAIL be0_err: got %b expected 0", e); end
    transact(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (rd !== 32'hDEADAAEF) begin failures++; $display("[TB] FAIL be0_nochange: got %h expected deadaaef", rd); end
  endtask

  task automatic test_errors();
    int n; logic [31:0] rd; logic e, af;
    transact(1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, n, rd, e, af);
    checks++; if (n !== 2) begin failures++; $display("[TB] FAIL w0_latency: got %0d expected 2", n); end
    transact(1'b1, 1'b0, 32'h2, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (n !== 2) begin failures++; $display("[TB] FAIL misal_latency: got %0d expected 2", n); end
    checks++; if (e !== 1'b1) begin failures++; $display("[TB] FAIL misal_err: got %b expected 1", e); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL misal_rdata: got %h expected 00000000", rd); end
    transact(1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, n, rd, e, af);
    checks++; if (e !== 1'b1) begin failures++; $display("[TB] FAIL oor_wr_err: got %b expected 1", e); end
    transact(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (e !== 1'b1) begin failures++; $display("[TB] FAIL oor_rd_err: got %b expected 1", e); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL oor_rd_rdata: got %h expected 00000000", rd); end
    transact(1'b1, 1'b1, 32'h1, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (e !== 1'b1) begin failures++; $display("[TB] FAIL misal_wr_err: got %b expected 1", e); end
    transact(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL err_nochange: got %h expected cafef00d", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("[TB] FAIL w0_rd_err: got %b expected 0", e); end
  endtask

  // Write accepted on edge 1; a held read is only taken in the IDLE cycle after DONE.
  task automatic test_req_ignored();
    int pulses, p1, p2; logic [31:0] d1, d2;
    pulses = 0; p1 = 0; p2 = 0; d1 = 'x; d2 = 'x;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus2.ready === 1'b1) begin
        pulses++;
        if (pulses == 1) begin p1 = k; d1 = bus2.rdata; end
        else begin p2 = k; d2 = bus2.rdata; end
      end
      @(negedge clk);
      case (k)
        1: drive(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        2: bus2.req = 1'b1;
        3: bus2.req = 1'b0;
        4: bus2.req = 1'b1;
        9: bus2.req = 1'b0;
        default: ;
      endcase
    end
    checks++; if (pulses !== 2) begin failures++; $display("[TB] FAIL ign_pulses: got %0d expected 2", pulses); end
    checks++; if (p1 !== 4) begin failures++; $display("[TB] FAIL ign_first_edge: got %0d expected 4", p1); end
    checks++; if (p2 !== 9) begin failures++; $display("[TB] FAIL ign_second_edge: got %0d expected 9", p2); end
    checks++; if (d1 !== 32'h0) begin failures++; $display("[TB] FAIL ign_wr_rdata: got %h expected 00000000", d1); end
    checks++; if (d2 !== 32'h12345678) begin failures++; $display("[TB] FAIL ign_rd_data: got %h expected 12345678", d2); end
  endtask

  task automatic test_reset_abort();
    int n; logic [31:0] rd; logic e, af;
    transact(1'b0, 1'b1, 32'h30, 32'h0, 4'hF, n, rd, e, af);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL ab_pre_latency: got %0d expected 4", n); end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 4'hF);
    #1;
    checks++; if (bus2.ready !== 1'b0) begin failures++; $display("[TB] FAIL ab_ready_at_rst: got %b expected 0", bus2.ready); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus2.ready !== 1'b0) begin failures++; $display("[TB] FAIL ab_ready_in_rst: got %b expected 0", bus2.ready); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    wait_ready(1'b0, n, rd, e, af);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL ab_first_accept: got %0d expected 4", n); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL ab_not_committed: got %h expected 00000000", rd); end
  endtask

  task automatic test_back_to_back();
    int n, pulses, p1, p2; logic [31:0] rd, d1, d2; logic e, af, leak;
    transact(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, n, rd, e, af);
    transact(1'b0, 1'b1, 32'h4, 32'h5A5A0001, 4'hF, n, rd, e, af);
    pulses = 0; p1 = 0; p2 = 0; d1 = 'x; d2 = 'x; leak = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (bus2.ready === 1'b1) begin
        pulses++;
        if (pulses == 1) begin p1 = k; d1 = bus2.rdata; end
        else begin p2 = k; d2 = bus2.rdata; end
        @(negedge clk);
        if (pulses == 1) bus2.addr = 32'h4; else bus2.req = 1'b0;
      end else begin
        if (bus2.rdata !== 32'h0 || bus2.err !== 1'b0) leak = 1'b1;
        @(negedge clk);
      end
    end
    checks++; if (pulses !== 2) begin failures++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulses); end
    checks++; if (p1 !== 4) begin failures++; $display("[TB] FAIL b2b_first_edge: got %0d expected 4", p1); end
    checks++; if (p2 !== 9) begin failures++; $display("[TB] FAIL b2b_second_edge: got %0d expected 9", p2); end
    checks++; if (d1 !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL b2b_data0: got %h expected a5a5a5a5", d1); end
    checks++; if (d2 !== 32'h5A5A0001) begin failures++; $display("[TB] FAIL b2b_data4: got %h expected 5a5a0001", d2); end
    checks++; if (leak !== 1'b0) begin failures++; $display("[TB] FAIL idle_outputs_zero: got %b expected 0", leak); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_errors();
    test_req_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the storage array, a power of two, minimum 4.
REQ-002 Parameter WAIT, default 2: wait states between request acceptance and the access cycle, range 0..15.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port req  input  1: initiator request valid, held high until ready is seen.
REQ-006 Port we  input  1: 1 = write, 0 = read; sampled at acceptance.
REQ-007 Port addr  input  32: byte address; sampled at acceptance.
REQ-008 Port wdata  input  32: write data; sampled at acceptance.
REQ-009 Port be  input  4: byte-lane enables; be[i] selects bits 8i+7..8i; sampled at acceptance.
REQ-010 Port ready  output  1: one-cycle completion strobe.
REQ-011 Port rdata  output  32: read data, valid while ready=1.
REQ-012 Port err  output  1: error flag, valid while ready=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with req=1, the block SHALL latch we, addr, wdata and be, load the wait counter with WAIT, and go to BUSY.
REQ-015 In BUSY with counter>0, the block SHALL decrement the counter and stay in BUSY.
REQ-016 In BUSY with counter=0, the block SHALL perform the access and go to DONE.
REQ-017 In DONE, the block SHALL assert ready for exactly one cycle and return to IDLE.
REQ-018 Latency SHALL be WAIT+2 cycles from the accepting edge to the cycle in which ready is high; with WAIT=0, ready SHALL be high 2 cycles after acceptance.
REQ-019 req SHALL be ignored in BUSY and DONE; no request queuing.
REQ-020 A new request SHALL be accepted in IDLE on the edge after a DONE cycle.
REQ-021 Word index SHALL be addr[31:2]; the request is in range only if addr[31:2] < DEPTH.
REQ-022 A write SHALL update only the byte lanes with be[i]=1; lanes with be[i]=0 keep their old contents.
REQ-023 A write with be=0 SHALL complete normally with no storage change.
REQ-024 A read SHALL return the full word; on a write completion, rdata SHALL be 0.
REQ-025 addr[1:0]!=0 or an out-of-range index SHALL make the access an error: no storage change, rdata=0, and err=1 together with ready.
REQ-026 err and rdata SHALL be 0 whenever ready=0.
REQ-027 A read of a word in the same transaction slot after a completed write SHALL return the merged data; there are no read/write hazards, because there is one outstanding request.

Reset
REQ-028 On reset assertion, the block SHALL asynchronously force: state=IDLE, counter=0, ready=0, err=0, rdata=0.
REQ-029 Reset during BUSY SHALL abort the transaction; a pending write SHALL NOT be committed.
REQ-030 Reset assertion during the access cycle SHALL leave that word with either its old or its fully new value, never a partial one.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 The first request SHALL be accepted on the first rising edge after reset deassertion with req=1.

Structure
REQ-033 Package mem_pkg SHALL hold the state enum (IDLE/BUSY/DONE), WORD_W=32, BE_W=4 and the counter width constant CNT_W=4.
REQ-034 The storage array and byte-lane write merge SHALL live in one sub-module, ram_bank (synchronous write, registered read, DEPTH parameter).
REQ-035 The FSM, wait counter, request latches and error decode SHALL live in mem_responder.

Verification
REQ-036 Bench: WAIT=2; write addr=0x10, wdata=0xDEADBEEF, be=0xF, then read 0x10 -> ready 4 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-037 Bench: word 0x10=0xDEADBEEF; write be=0x2, wdata=0x0000AA00; read 0x10 -> rdata=0xDEADAAEF.
REQ-038 Bench: WAIT=0; read addr=0x2 -> ready after 2 cycles, err=1, rdata=0; then read addr=4*DEPTH -> err=1, storage unchanged.
REQ-039 Bench: write 0x20=0x12345678; toggle req during BUSY -> exactly one ready pulse; second request accepted only after DONE.
REQ-040 Bench: word 0x30=0x0; write 0x30=0xFFFFFFFF with reset pulsed mid-BUSY -> ready stays 0; a later read of 0x30 returns 0x00000000.
REQ-041 Bench: back-to-back reads at 0x0 and 0x4 with req held -> ready pulses one cycle wide, separated by one IDLE cycle.
